// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: a one-entry fetch buffer between the core's ROM port
// and an ack-based external instruction memory, with timeout and misalignment handling.
module inst_fetch_bridge #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        fetch_err_o
);

  localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          buf_valid_q, buf_valid_d;
  logic [31:0]   buf_addr_q, buf_addr_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic          err_q, err_d;
  logic          hit_s;

  assign hit_s       = rom_ce_i & buf_valid_q & (buf_addr_q == rom_addr_i);
  assign rom_data_o  = hit_s ? buf_data_q : NOP_WORD;
  assign stallreq_o  = rom_ce_i & ~hit_s;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign fetch_err_o = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h00000000;
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= 32'h00000000;
      buf_data_q  <= 32'h00000000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    cnt_d       = cnt_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // mem_ack_i is deliberately not looked at here
        if (rom_ce_i && !hit_s) begin
          if (rom_addr_i[1:0] == 2'b00) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = rom_addr_i;
            cnt_d      = '0;
          end else begin
            buf_valid_d = 1'b1;
            buf_addr_d  = rom_addr_i;
            buf_data_d  = NOP_WORD;
            err_d       = 1'b1;
          end
        end
      end
      REQ: begin
        // Ack wins over a timeout landing in the same cycle
        if (mem_ack_i) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = mem_addr_q;
          buf_data_d  = mem_rdata_i;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = mem_addr_q;
          buf_data_d  = NOP_WORD;
          mem_req_d   = 1'b0;
          err_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge: directed vector table, hand-written
// corner sequences, and random fetches checked against a transaction-level model.
module tb_inst_fetch_bridge;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] NOP_WORD = 32'h00000000;

  logic        clk, rst, rom_ce_i, stallreq_o, mem_req_o, mem_ack_i, fetch_err_o;
  logic [31:0] rom_addr_i, rom_data_o, mem_addr_o, mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  // Model state: what the one-entry buffer should hold
  bit          m_valid;
  logic [31:0] m_addr, m_data;

  typedef struct {
    logic [31:0] addr;
    int          w;
    logic [31:0] data;
    int          e_st;
    logic [31:0] e_dat;
    int          e_req;
    int          e_err;
  } vec_t;

  vec_t vecs[9];

  inst_fetch_bridge #(.TIMEOUT(TIMEOUT), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
    .rom_data_o(rom_data_o), .stallreq_o(stallreq_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .fetch_err_o(fetch_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected outcome of one fetch, derived from the buffer contents and the ack delay
  task automatic model_fetch(input logic [31:0] a, input int w, input logic [31:0] d,
                             output int e_st, output logic [31:0] e_dat,
                             output int e_req, output int e_err);
    if (m_valid && m_addr == a) begin
      e_st = 0; e_req = 0; e_err = 0; e_dat = m_data;
    end else begin
      m_valid = 1'b1;
      m_addr  = a;
      e_err   = 0;
      if (a[1:0] != 2'b00) begin
        e_st = 1; e_req = 0; e_err = 1; m_data = NOP_WORD;
      end else if (w < TIMEOUT) begin
        e_st = 2 + w; e_req = w + 1; m_data = d;
      end else begin
        e_st = 1 + TIMEOUT; e_req = TIMEOUT; e_err = 1; m_data = NOP_WORD;
      end
      e_dat = m_data;
    end
  endtask

  // Entered and left 1ns after a rising edge; memory acks after w waiting REQ cycles
  task automatic run_fetch(input string nm, input logic [31:0] a, input int w,
                           input logic [31:0] d, input int e_st, input logic [31:0] e_dat,
                           input int e_req, input int e_err);
    int st, rq, er, wn, badaddr;
    bit done, req_now, ack_now;
    st = 0; rq = 0; er = 0; wn = 0; badaddr = 0; done = 1'b0;
    rom_ce_i   = 1'b1;
    rom_addr_i = a;
    for (int c = 0; c < 64 && !done; c++) begin
      mem_ack_i   = mem_req_o && (wn == w);
      mem_rdata_i = mem_ack_i ? d : $urandom;
      #4;
      if (!stallreq_o) begin
        done = 1'b1;
        chk({nm, " data"}, rom_data_o, e_dat);
        #5;
      end else begin
        st++;
        if (mem_req_o) begin
          rq++;
          if (mem_addr_o !== a) badaddr++;
        end
        req_now = mem_req_o;
        ack_now = mem_ack_i;
        @(posedge clk); #1;
        if (req_now && !ack_now) wn++;
        if (fetch_err_o) er++;
      end
    end
    mem_ack_i = 1'b0;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: stall still high after 64 cycles", nm);
    end
    @(posedge clk); #1;
    if (fetch_err_o) er++;
    chk({nm, " stalls"}, 32'(st), 32'(e_st));
    chk({nm, " reqs"}, 32'(rq), 32'(e_req));
    chk({nm, " errs"}, 32'(er), 32'(e_err));
    chk({nm, " addr_stable"}, 32'(badaddr), 32'd0);
  endtask

  initial begin
    int          e_st, e_req, e_err, w;
    logic [31:0] e_dat, a, d;

    vecs[0] = '{32'h00000000, 2,  32'h34011100, 4,  32'h34011100, 3,  0};
    vecs[1] = '{32'h00000000, 0,  32'h11111111, 0,  32'h34011100, 0,  0};
    vecs[2] = '{32'h00000004, 5,  32'hAABBCCDD, 7,  32'hAABBCCDD, 6,  0};
    vecs[3] = '{32'h00000008, 99, 32'h22222222, 17, 32'h00000000, 16, 1};
    vecs[4] = '{32'h00000008, 0,  32'h33333333, 0,  32'h00000000, 0,  0};
    vecs[5] = '{32'h00000006, 0,  32'h44444444, 1,  32'h00000000, 0,  1};
    vecs[6] = '{32'h00000010, 15, 32'h12345678, 17, 32'h12345678, 16, 0};
    vecs[7] = '{32'h00000014, 14, 32'hCAFEF00D, 16, 32'hCAFEF00D, 15, 0};
    vecs[8] = '{32'h00000014, 3,  32'h55555555, 0,  32'hCAFEF00D, 0,  0};

    rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    #2;
    chk("rst mem_req", 32'(mem_req_o), 32'd0);
    chk("rst mem_addr", mem_addr_o, 32'h0);
    chk("rst err", 32'(fetch_err_o), 32'd0);
    chk("rst data", rom_data_o, NOP_WORD);
    chk("rst stall ce0", 32'(stallreq_o), 32'd0);
    rom_ce_i = 1'b1; #1;
    chk("rst stall ce1", 32'(stallreq_o), 32'd1);
    rom_ce_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].w, vecs[i].data,
                vecs[i].e_st, vecs[i].e_dat, vecs[i].e_req, vecs[i].e_err);

    // Address change mid-request, in-flight completion with ce low, ack ignored in IDLE
    rom_ce_i = 1'b1; rom_addr_i = 32'h20; #4;
    chk("seq miss20 stall", 32'(stallreq_o), 32'd1);
    @(posedge clk); #1;
    chk("seq req20", 32'(mem_req_o), 32'd1);
    rom_addr_i = 32'h24; #4;
    chk("seq chg stall", 32'(stallreq_o), 32'd1);
    @(posedge clk); #1;
    chk("seq addr held", mem_addr_o, 32'h20);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    chk("seq req dropped", 32'(mem_req_o), 32'd0);
    rom_addr_i = 32'h20; #1;
    chk("seq hit20 stall", 32'(stallreq_o), 32'd0);
    chk("seq hit20 data", rom_data_o, 32'h55555555);
    rom_addr_i = 32'h24; #2;
    chk("seq miss24 stall", 32'(stallreq_o), 32'd1);
    @(posedge clk); #1;
    chk("seq req24", 32'(mem_req_o), 32'd1);
    chk("seq addr24", mem_addr_o, 32'h24);
    rom_ce_i = 1'b0; #1;
    chk("seq ce0 stall", 32'(stallreq_o), 32'd0);
    chk("seq ce0 data", rom_data_o, NOP_WORD);
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h66666666;
    @(posedge clk); #1;
    mem_rdata_i = 32'h77777777;
    chk("seq inflight done", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    chk("seq idle ack no req", 32'(mem_req_o), 32'd0);
    rom_ce_i = 1'b1; #1;
    chk("seq hit24 stall", 32'(stallreq_o), 32'd0);
    chk("seq hit24 data", rom_data_o, 32'h66666666);
    rom_ce_i = 1'b0;

    // Reset during REQ with an ack pending
    @(posedge clk); #1;
    rom_ce_i = 1'b1; rom_addr_i = 32'h0;
    @(posedge clk); #1;
    chk("rstreq req", 32'(mem_req_o), 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #2;
    rst = 1'b1; #1;
    chk("rstreq req async", 32'(mem_req_o), 32'd0);
    chk("rstreq addr", mem_addr_o, 32'h0);
    chk("rstreq stall", 32'(stallreq_o), 32'd1);
    chk("rstreq data", rom_data_o, NOP_WORD);
    @(posedge clk); #1;
    rom_ce_i = 1'b0; mem_ack_i = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rom_ce_i = 1'b1; rom_addr_i = 32'h0; #1;
    chk("rstreq miss0", 32'(stallreq_o), 32'd1);
    rom_addr_i = 32'h24; #1;
    chk("rstreq miss24", 32'(stallreq_o), 32'd1);
    rom_ce_i = 1'b0;
    @(posedge clk); #1;
    chk("rstreq no err", 32'(fetch_err_o), 32'd0);

    // Random fetches against the model
    m_valid = 1'b0; m_addr = 32'h0; m_data = 32'h0;
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) w = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
      else w = int'($urandom_range(0, 4));
      d = $urandom;
      model_fetch(a, w, d, e_st, e_dat, e_req, e_err);
      run_fetch($sformatf("rnd%0d", i), a, w, d, e_st, e_dat, e_req, e_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
